spi_ram_reader: RTL
===================

# spi_ram_reader

Avalon-MM master that fetches a block of 32-bit words from the on-chip SPI buffer RAM (the single-port, byte-enabled slave with 51200 words) and presents them in address order on an Avalon-ST source, typically the SPI transmit path. A simple start/length command interface drives it. An internal FIFO with read-credit accounting sustains one word per clock when the sink keeps up. It never stalls the interconnect with responses it cannot store.

## Interface
Parameters:
- ADDR_W, 16: word-address width; matches the RAM slave address port.
- FIFO_DEPTH, 8: output FIFO depth in words; power of two, ≥2.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; captured on start.
- length  in  16  number of words to read; captured on start.
- abort  in  1  cancels the transfer in progress; ignored in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a transfer completes or finishes aborting.
- avm_address  out  ADDR_W  word address of the current read.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read response data.
- avm_readdatavalid  in  1  read response strobe; pipelined, in order.
- src_data  out  32  stream data; don't-care while src_valid=0.
- src_valid  out  1  stream valid.
- src_ready  in  1  stream backpressure.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with length≠0: capture base_addr/length, go to RUN.
  - start=1 with length=0: go to DONE; no reads are issued.
- RUN:
  - issue reads at consecutive addresses, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - Go to DONE when issued=length, outstanding=0 and the FIFO is empty (all words delivered).
  - abort=1 goes to DRAIN.
- DRAIN:
  - no new reads, except an already-asserted avm_read is held until it is accepted.
  - Flush the FIFO and discard arriving responses; src_valid=0.
  - Go to DONE when outstanding=0.
- DONE: assert done for one cycle, return to IDLE.
- Read accepted = avm_read & ~avm_waitrequest.
  - Counters: outstanding (+1 on accept, −1 on readdatavalid; both events in one cycle leave it unchanged) and issued.
- Credit rule: a new avm_read is asserted only while outstanding + fifo_count < FIFO_DEPTH. The FIFO therefore never overflows, and avm_readdatavalid is never backpressured.
- Stream word accepted = src_valid & src_ready.
  - A simultaneous FIFO write and read leaves fifo_count unchanged.
  - A write into an empty FIFO and a read in the same cycle is impossible; the FIFO is not show-through.
- start while busy is ignored. abort in IDLE or DONE is ignored.
- Counters are sized to hold FIFO_DEPTH and 2^16−1 without overflow. The length range is 1..65535.

## Timing
- Reset values: busy=0, done=0, avm_read=0, avm_address=0, src_valid=0, src_data=0, state IDLE, all counters 0.
- Reset asserted mid-transfer: return to reset values immediately; any responses in flight are lost.
- start at cycle T:
  - busy=1 and avm_read=1 with avm_address=base_addr at T+1.
  - For length=0: done=1 at T+1, busy stays 0.
- avm_address and avm_read are held stable while avm_waitrequest=1.
  - The address advances in the cycle after an accept.
  - With no stall and credit available, avm_read stays high and one read is accepted per cycle.
- readdatavalid at cycle R: the word appears on src_data with src_valid=1 at R+1.
- With a fixed-latency-1 slave, no waitrequest and src_ready=1, a length-N transfer takes:
  - first src_valid at T+3;
  - last word at T+N+2;
  - done pulse at T+N+3, with busy falling the same cycle.
- abort at cycle A: src_valid=0 from A+1, and done follows once outstanding reaches 0.

## Test plan
- base_addr=0x0100, length=4, RAM preloaded with 0xA0..0xA3, src_ready=1 → reads at 0x0100..0x0103 and stream words 0xA0,0xA1,0xA2,0xA3 in order. This checks the T+1/T+3 latencies, one done pulse, and busy falling with done.
- length=0 → done at T+1, no avm_read, busy never rises.
- base_addr=0xFFFE, length=4 → addresses 0xFFFE,0xFFFF,0x0000,0x0001.
- length=32, src_ready=0 for 20 cycles then 1 → exactly FIFO_DEPTH=8 reads accepted while stalled, and the FIFO never exceeds 8. All 32 words arrive in order.
- length=16, random avm_waitrequest (50%) and random src_ready → address stable during each stall, no lost or duplicated words, outstanding returns to 0.
- length=100, abort after 10 words delivered → src_valid drops the next cycle, no reads issued after the pending one, done pulses once outstanding=0. A new start then runs normally. Repeat with reset_n low mid-transfer → all outputs at reset values.

Source files
------------

// File: rtl/spi_ram_reader_if.sv
// -----------------------------------------------------------------------------
// spi_ram_reader_if
//   Bundles the two bus sides of spi_ram_reader: the Avalon-MM read master
//   that talks to the SPI buffer RAM, and the Avalon-ST source that feeds the
//   SPI transmit path.
//
//   Signals
//     avm_address       word address of the current read (master -> slave)
//     avm_read          read request                      (master -> slave)
//     avm_waitrequest   slave stall                       (slave -> master)
//     avm_readdata      read response data                (slave -> master)
//     avm_readdatavalid read response strobe, in order    (slave -> master)
//     src_data          stream data                       (master -> sink)
//     src_valid         stream valid                      (master -> sink)
//     src_ready         stream backpressure               (sink -> master)
//
//   Modports
//     master  the reader's view
//     slave   the RAM / sink view
// -----------------------------------------------------------------------------
interface spi_ram_reader_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       src_data;
  logic              src_valid;
  logic              src_ready;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output src_data, src_valid,
    input  src_ready
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  src_data, src_valid,
    output src_ready
  );
endinterface

// File: rtl/spi_ram_reader.sv
// -----------------------------------------------------------------------------
// spi_ram_reader
//   Avalon-MM master that reads a block of 32-bit words from the SPI buffer
//   RAM and streams them, in address order, on an Avalon-ST source. Reads are
//   only issued while the local FIFO has room for every response already in
//   flight, so read responses never need to be backpressured.
//
//   Parameters
//     ADDR_W      word-address width of the RAM slave
//     FIFO_DEPTH  output FIFO depth in words (power of two, >= 2)
//
//   Ports
//     clk, reset_n   clock and asynchronous active-low reset
//     start          one-cycle command strobe, sampled only in IDLE
//     base_addr      first word address, captured on start
//     length         number of words, captured on start (0 = no reads)
//     abort          cancels a running transfer
//     busy           high while a transfer is running or aborting
//     done           one-cycle completion pulse
//     bus            Avalon-MM master + Avalon-ST source (spi_ram_reader_if)
// -----------------------------------------------------------------------------
module spi_ram_reader #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  spi_ram_reader_if.master  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // One extra bit so the counters can hold FIFO_DEPTH itself.
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_n;

  // Command and read bookkeeping
  logic [15:0]       len_q;
  logic [15:0]       issued, issued_n;
  logic [CNT_W-1:0]  outstanding, outstanding_n;
  logic              avm_read_q;
  logic [ADDR_W-1:0] avm_address_q;

  // Output FIFO
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count, fifo_count_n;

  // Per-cycle events
  logic rd_accept;
  logic rd_stalled;
  logic fifo_wr;
  logic fifo_rd;
  logic fifo_flush;
  logic src_valid;
  logic want_read;

  // ---------------------------------------------------------------------------
  // Event decode and next counter values. The credit check looks at the
  // counters as they will be after this edge, because avm_read is registered
  // and the request it launches lands one cycle later.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so this block
    // stays purely combinational; blocking '=' is correct here, unlike the
    // '<=' used for clocked state below.
    rd_accept     = avm_read_q & ~bus.avm_waitrequest;
    rd_stalled    = avm_read_q & bus.avm_waitrequest;
    src_valid     = (state == RUN) && (fifo_count != '0);
    fifo_wr       = bus.avm_readdatavalid && (state == RUN);
    fifo_rd       = src_valid && bus.src_ready;
    fifo_flush    = (state != RUN) || abort;
    issued_n      = issued + {15'd0, rd_accept};
    outstanding_n = outstanding;
    fifo_count_n  = fifo_count;

    unique case ({rd_accept, bus.avm_readdatavalid})
      2'b10:   outstanding_n = outstanding + CNT_W'(1);
      2'b01:   outstanding_n = outstanding - CNT_W'(1);
      default: outstanding_n = outstanding;
    endcase

    unique case ({fifo_wr, fifo_rd})
      2'b10:   fifo_count_n = fifo_count + CNT_W'(1);
      2'b01:   fifo_count_n = fifo_count - CNT_W'(1);
      default: fifo_count_n = fifo_count;
    endcase

    want_read = (issued_n < len_q) &&
                (({1'b0, outstanding_n} + {1'b0, fifo_count_n}) < CREDIT_LIMIT);
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (length == 16'd0) ? DONE : RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_n = DRAIN;
        end else if ((issued_n == len_q) && (outstanding_n == '0) &&
                     (fifo_count_n == '0)) begin
          // Last word leaves the FIFO on this edge.
          state_n = DONE;
        end
      end

      DRAIN: begin
        busy = 1'b1;
        // A read still stalled on the bus would add one more response, so
        // wait for it to be accepted and answered too.
        if ((outstanding_n == '0) && !rd_stalled) begin
          state_n = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read master and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read_q    <= 1'b0;
      avm_address_q <= '0;
      len_q         <= '0;
      issued        <= '0;
      outstanding   <= '0;
    end else begin
      outstanding <= outstanding_n;

      // Address moves only once the slave has taken the current request, so
      // it is stable for the whole of any stall.
      if (rd_accept) begin
        avm_address_q <= avm_address_q + ADDR_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (start && (length != 16'd0)) begin
            avm_read_q    <= 1'b1;
            avm_address_q <= base_addr;
            len_q         <= length;
            issued        <= '0;
          end
        end

        RUN: begin
          issued     <= issued_n;
          avm_read_q <= rd_stalled | (want_read & ~abort);
        end

        // Only a request already on the bus survives an abort.
        DRAIN:   avm_read_q <= rd_stalled;

        default: avm_read_q <= 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (fifo_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      fifo_count <= fifo_count_n;
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed
  // through fifo_count/rd_ptr, which are reset, so clearing it would buy
  // nothing and would keep it out of RAM-style resources.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= bus.avm_readdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. src_data is forced to zero while idle so it comes out of reset
  // at zero even though the array itself is not cleared.
  // ---------------------------------------------------------------------------
  assign bus.avm_read    = avm_read_q;
  assign bus.avm_address = avm_address_q;
  assign bus.src_valid   = src_valid;
  assign bus.src_data    = src_valid ? fifo_mem[rd_ptr] : 32'd0;

endmodule
